// File: rtl/ysyx_040750_rd_arbiter.sv
// Two-master (IFU/LSU) read-channel arbiter onto a single AR/R slave port.
// One single-beat transaction in flight; every transaction returns through IDLE.
module ysyx_040750_rd_arbiter #(
  parameter int LSU_PRIO = 1,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic [ADDR_W-1:0] I_ifu_araddr,
  input  logic              I_ifu_arvalid,
  output logic              O_ifu_arready,
  output logic [DATA_W-1:0] O_ifu_rdata,
  output logic              O_ifu_rvalid,
  input  logic              I_ifu_rready,
  input  logic [ADDR_W-1:0] I_lsu_araddr,
  input  logic              I_lsu_arvalid,
  output logic              O_lsu_arready,
  output logic [DATA_W-1:0] O_lsu_rdata,
  output logic              O_lsu_rvalid,
  input  logic              I_lsu_rready,
  output logic [ADDR_W-1:0] O_mem_araddr,
  output logic              O_mem_arvalid,
  input  logic              I_mem_arready,
  input  logic [DATA_W-1:0] I_mem_rdata,
  input  logic              I_mem_rvalid,
  output logic              O_mem_rready,
  output logic [1:0]        O_grant
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]        r_state;
  logic              r_own;
  logic              r_last;
  logic [1:0]        w_state_nxt;
  logic              w_own_nxt;
  logic              w_last_nxt;
  logic              w_pick_lsu;
  logic              w_own_arvalid;
  logic [ADDR_W-1:0] w_own_araddr;
  logic              w_own_rready;

  // Owner-side view of the AR valid/address and R ready
  always_comb begin
    w_own_arvalid = 1'b0;
    w_own_araddr  = {ADDR_W{1'b0}};
    w_own_rready  = 1'b0;
    if (r_own == OWN_LSU) begin
      w_own_arvalid = I_lsu_arvalid;
      w_own_araddr  = I_lsu_araddr;
      w_own_rready  = I_lsu_rready;
    end else begin
      w_own_arvalid = I_ifu_arvalid;
      w_own_araddr  = I_ifu_araddr;
      w_own_rready  = I_ifu_rready;
    end
  end

  // Tie-break: fixed LSU priority, or alternate away from the last grant
  always_comb begin
    w_pick_lsu = 1'b0;
    if (I_ifu_arvalid && I_lsu_arvalid) begin
      if (LSU_PRIO != 0) begin
        w_pick_lsu = 1'b1;
      end else begin
        w_pick_lsu = (r_last == OWN_IFU);
      end
    end else begin
      w_pick_lsu = I_lsu_arvalid;
    end
  end

  // Next-state, owner and last-grant selection
  always_comb begin
    w_state_nxt = r_state;
    w_own_nxt   = r_own;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (I_ifu_arvalid || I_lsu_arvalid) begin
          w_own_nxt   = w_pick_lsu ? OWN_LSU : OWN_IFU;
          w_last_nxt  = w_pick_lsu ? OWN_LSU : OWN_IFU;
          w_state_nxt = S_ADDR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ADDR: begin
        // A request withdrawn mid-address is abandoned without issuing anything
        if (!w_own_arvalid) begin
          w_state_nxt = S_IDLE;
        end else if (I_mem_arready) begin
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_ADDR;
        end
      end
      S_DATA: begin
        if (I_mem_rvalid && w_own_rready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state <= S_IDLE;
      r_own   <= OWN_IFU;
      r_last  <= OWN_IFU;
    end else begin
      r_state <= w_state_nxt;
      r_own   <= w_own_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Channel steering; everything idles at zero outside the owner's active phase
  always_comb begin
    O_ifu_arready = 1'b0;
    O_lsu_arready = 1'b0;
    O_ifu_rvalid  = 1'b0;
    O_lsu_rvalid  = 1'b0;
    O_ifu_rdata   = {DATA_W{1'b0}};
    O_lsu_rdata   = {DATA_W{1'b0}};
    O_mem_araddr  = {ADDR_W{1'b0}};
    O_mem_arvalid = 1'b0;
    O_mem_rready  = 1'b0;
    O_grant       = 2'b00;
    case (r_state)
      S_ADDR: begin
        O_mem_araddr  = w_own_araddr;
        O_mem_arvalid = w_own_arvalid;
        O_grant       = (r_own == OWN_LSU) ? 2'b10 : 2'b01;
        if (r_own == OWN_LSU) begin
          O_lsu_arready = I_mem_arready;
        end else begin
          O_ifu_arready = I_mem_arready;
        end
      end
      S_DATA: begin
        O_mem_rready = w_own_rready;
        O_grant      = (r_own == OWN_LSU) ? 2'b10 : 2'b01;
        if (r_own == OWN_LSU) begin
          O_lsu_rvalid = I_mem_rvalid;
          O_lsu_rdata  = I_mem_rdata;
        end else begin
          O_ifu_rvalid = I_mem_rvalid;
          O_ifu_rdata  = I_mem_rdata;
        end
      end
      default: begin
        O_grant = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_040750_rd_arbiter.sv
// Directed bench for the IFU/LSU read arbiter: a fixed-priority instance and
// a round-robin instance share all inputs; expectations are hand-computed.
module tb_ysyx_040750_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr, lsu_araddr;
  logic        ifu_arvalid, lsu_arvalid, ifu_rready, lsu_rready;
  logic        mem_arready, mem_rvalid;
  logic [63:0] mem_rdata;

  logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, mem_arvalid, mem_rready;
  logic [63:0] ifu_rdata, lsu_rdata;
  logic [31:0] mem_araddr;
  logic [1:0]  grant;

  logic        rr_ifu_arready, rr_ifu_rvalid, rr_lsu_arready, rr_lsu_rvalid, rr_mem_arvalid, rr_mem_rready;
  logic [63:0] rr_ifu_rdata, rr_lsu_rdata;
  logic [31:0] rr_mem_araddr;
  logic [1:0]  rr_grant;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_040750_rd_arbiter #(.LSU_PRIO(1), .ADDR_W(32), .DATA_W(64)) dut (
    .I_clk(clk), .I_rst(rst),
    .I_ifu_araddr(ifu_araddr), .I_ifu_arvalid(ifu_arvalid), .O_ifu_arready(ifu_arready),
    .O_ifu_rdata(ifu_rdata), .O_ifu_rvalid(ifu_rvalid), .I_ifu_rready(ifu_rready),
    .I_lsu_araddr(lsu_araddr), .I_lsu_arvalid(lsu_arvalid), .O_lsu_arready(lsu_arready),
    .O_lsu_rdata(lsu_rdata), .O_lsu_rvalid(lsu_rvalid), .I_lsu_rready(lsu_rready),
    .O_mem_araddr(mem_araddr), .O_mem_arvalid(mem_arvalid), .I_mem_arready(mem_arready),
    .I_mem_rdata(mem_rdata), .I_mem_rvalid(mem_rvalid), .O_mem_rready(mem_rready),
    .O_grant(grant)
  );

  ysyx_040750_rd_arbiter #(.LSU_PRIO(0), .ADDR_W(32), .DATA_W(64)) dut_rr (
    .I_clk(clk), .I_rst(rst),
    .I_ifu_araddr(ifu_araddr), .I_ifu_arvalid(ifu_arvalid), .O_ifu_arready(rr_ifu_arready),
    .O_ifu_rdata(rr_ifu_rdata), .O_ifu_rvalid(rr_ifu_rvalid), .I_ifu_rready(ifu_rready),
    .I_lsu_araddr(lsu_araddr), .I_lsu_arvalid(lsu_arvalid), .O_lsu_arready(rr_lsu_arready),
    .O_lsu_rdata(rr_lsu_rdata), .O_lsu_rvalid(rr_lsu_rvalid), .I_lsu_rready(lsu_rready),
    .O_mem_araddr(rr_mem_araddr), .O_mem_arvalid(rr_mem_arvalid), .I_mem_arready(mem_arready),
    .I_mem_rdata(mem_rdata), .I_mem_rvalid(mem_rvalid), .O_mem_rready(rr_mem_rready),
    .O_grant(rr_grant)
  );

  // Inputs change just after the rising edge; outputs are sampled on the falling edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ifu_araddr = 32'h0; lsu_araddr = 32'h0; ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    ifu_rready = 1'b0; lsu_rready = 1'b0; mem_arready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 64'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    cyc(); cyc();
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0001; mem_arready = 1'b1;
    smp();
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant); end
    total++; if ({ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, mem_arvalid, mem_rready} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000", {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, mem_arvalid, mem_rready}); end
    total++; if ({ifu_rdata, lsu_rdata, mem_araddr} !== 160'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {ifu_rdata, lsu_rdata, mem_araddr}); end
    cyc();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_ifu_only();
    do_reset();
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1; mem_arready = 1'b1; ifu_rready = 1'b1;
    smp();
    total++; if (grant !== 2'b00 || ifu_arready !== 1'b0) begin bad++; $display("FAIL ifu_c0 grant=%b arready=%b exp 00/0", grant, ifu_arready); end
    cyc();
    smp();
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL ifu_c1_grant got=%b exp=01", grant); end
    total++; if (ifu_arready !== 1'b1 || mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0000) begin
      bad++; $display("FAIL ifu_c1_ar arready=%b arvalid=%b araddr=%h exp 1/1/80000000", ifu_arready, mem_arvalid, mem_araddr); end
    total++; if (lsu_arready !== 1'b0) begin bad++; $display("FAIL ifu_c1_lsu_arready got=%b exp=0", lsu_arready); end
    cyc();
    ifu_arvalid = 1'b0; mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
    smp();
    total++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 64'h1122_3344_5566_7788) begin
      bad++; $display("FAIL ifu_c2_r rvalid=%b rdata=%h exp 1/1122334455667788", ifu_rvalid, ifu_rdata); end
    total++; if (mem_rready !== 1'b1 || grant !== 2'b01 || mem_araddr !== 32'h0) begin
      bad++; $display("FAIL ifu_c2_ctl rready=%b grant=%b araddr=%h exp 1/01/0", mem_rready, grant, mem_araddr); end
    total++; if (lsu_rvalid !== 1'b0 || lsu_rdata !== 64'h0) begin bad++; $display("FAIL ifu_c2_lsu rvalid=%b rdata=%h exp 0/0", lsu_rvalid, lsu_rdata); end
    cyc();
    mem_rvalid = 1'b0;
    smp();
    total++; if (grant !== 2'b00 || ifu_rvalid !== 1'b0) begin bad++; $display("FAIL ifu_c3_idle grant=%b rvalid=%b exp 00/0", grant, ifu_rvalid); end
    clear_inputs();
  endtask

  task automatic test_lsu_priority();
    do_reset();
    ifu_araddr = 32'h8000_0004; lsu_araddr = 32'h0200_BFF8; ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    mem_arready = 1'b1; ifu_rready = 1'b1; lsu_rready = 1'b1;
    cyc();
    smp();
    total++; if (grant !== 2'b10 || mem_araddr !== 32'h0200_BFF8) begin bad++; $display("FAIL prio_lsu_ar grant=%b araddr=%h exp 10/0200bff8", grant, mem_araddr); end
    total++; if (lsu_arready !== 1'b1 || ifu_arready !== 1'b0) begin bad++; $display("FAIL prio_arready lsu=%b ifu=%b exp 1/0", lsu_arready, ifu_arready); end
    cyc();
    lsu_arvalid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_0012_3456;
    smp();
    total++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 64'h0000_0000_0012_3456 || ifu_rvalid !== 1'b0 || ifu_arready !== 1'b0) begin
      bad++; $display("FAIL prio_lsu_r lrv=%b lrd=%h irv=%b iar=%b exp 1/123456/0/0", lsu_rvalid, lsu_rdata, ifu_rvalid, ifu_arready); end
    cyc();
    mem_rvalid = 1'b0;
    smp();
    total++; if (grant !== 2'b00 || ifu_arready !== 1'b0) begin bad++; $display("FAIL prio_idle grant=%b iar=%b exp 00/0", grant, ifu_arready); end
    cyc();
    smp();
    total++; if (grant !== 2'b01 || ifu_arready !== 1'b1 || mem_araddr !== 32'h8000_0004) begin
      bad++; $display("FAIL prio_ifu_ar grant=%b iar=%b araddr=%h exp 01/1/80000004", grant, ifu_arready, mem_araddr); end
    cyc();
    ifu_arvalid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hA5A5_0000_FFFF_0001;
    smp();
    total++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 64'hA5A5_0000_FFFF_0001 || lsu_rvalid !== 1'b0) begin
      bad++; $display("FAIL prio_ifu_r irv=%b ird=%h lrv=%b exp 1/a5a50000ffff0001/0", ifu_rvalid, ifu_rdata, lsu_rvalid); end
    clear_inputs();
    cyc();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rr [4];
    exp_rr[0] = 2'b10; exp_rr[1] = 2'b01; exp_rr[2] = 2'b10; exp_rr[3] = 2'b01;
    do_reset();
    ifu_araddr = 32'h8000_0100; lsu_araddr = 32'h8000_0200; ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    mem_arready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h5; ifu_rready = 1'b1; lsu_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      total++; if (rr_grant !== 2'b00) begin bad++; $display("FAIL rr_idle[%0d] got=%b exp=00", i, rr_grant); end
      cyc();
      smp();
      total++; if (rr_grant !== exp_rr[i]) begin bad++; $display("FAIL rr_order[%0d] got=%b exp=%b", i, rr_grant, exp_rr[i]); end
      total++; if (grant !== 2'b10) begin bad++; $display("FAIL prio_hold[%0d] got=%b exp=10", i, grant); end
      cyc();
      cyc();
    end
    clear_inputs();
  endtask

  task automatic test_rready_stall();
    do_reset();
    ifu_araddr = 32'h8000_0040; ifu_arvalid = 1'b1; mem_arready = 1'b1; ifu_rready = 1'b0;
    cyc();
    cyc();
    ifu_arvalid = 1'b0; mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hCAFE_F00D_1234_5678;
    for (int i = 0; i < 5; i++) begin
      smp();
      total++; if (grant !== 2'b01 || mem_rready !== 1'b0 || ifu_rvalid !== 1'b1 || ifu_rdata !== 64'hCAFE_F00D_1234_5678) begin
        bad++; $display("FAIL stall[%0d] grant=%b rready=%b rvalid=%b rdata=%h exp 01/0/1/cafef00d12345678", i, grant, mem_rready, ifu_rvalid, ifu_rdata); end
      cyc();
    end
    ifu_rready = 1'b1;
    smp();
    total++; if (mem_rready !== 1'b1 || grant !== 2'b01) begin bad++; $display("FAIL stall_release rready=%b grant=%b exp 1/01", mem_rready, grant); end
    cyc();
    smp();
    total++; if (grant !== 2'b00 || ifu_rvalid !== 1'b0 || mem_rready !== 1'b0) begin
      bad++; $display("FAIL stall_idle grant=%b rvalid=%b rready=%b exp 00/0/0", grant, ifu_rvalid, mem_rready); end
    clear_inputs();
  endtask

  task automatic test_reset_in_addr();
    do_reset();
    lsu_araddr = 32'h0200_4000; lsu_arvalid = 1'b1; mem_arready = 1'b0; lsu_rready = 1'b1;
    cyc();
    smp();
    total++; if (grant !== 2'b10 || mem_arvalid !== 1'b1 || lsu_arready !== 1'b0) begin
      bad++; $display("FAIL rst_pre grant=%b arvalid=%b arready=%b exp 10/1/0", grant, mem_arvalid, lsu_arready); end
    rst = 1'b1;
    cyc();
    smp();
    total++; if (grant !== 2'b00 || mem_arvalid !== 1'b0 || mem_araddr !== 32'h0 || lsu_arready !== 1'b0 || lsu_rvalid !== 1'b0) begin
      bad++; $display("FAIL rst_addr grant=%b arvalid=%b araddr=%h arready=%b rvalid=%b exp 00/0/0/0/0", grant, mem_arvalid, mem_araddr, lsu_arready, lsu_rvalid); end
    rst = 1'b0;
    clear_inputs();
    cyc();
  endtask

  task automatic test_arvalid_drop();
    do_reset();
    ifu_araddr = 32'h8000_0080; ifu_arvalid = 1'b1; mem_arready = 1'b0;
    cyc();
    ifu_arvalid = 1'b0;
    smp();
    total++; if (mem_arvalid !== 1'b0 || grant !== 2'b01) begin bad++; $display("FAIL drop_addr arvalid=%b grant=%b exp 0/01", mem_arvalid, grant); end
    cyc();
    smp();
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL drop_idle grant=%b exp=00", grant); end
    clear_inputs();
  endtask

  task automatic test_stray_rvalid();
    do_reset();
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; ifu_rready = 1'b1; lsu_rready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      smp();
      total++; if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0 || mem_rready !== 1'b0 || ifu_rdata !== 64'h0 || lsu_rdata !== 64'h0) begin
        bad++; $display("FAIL stray[%0d] irv=%b lrv=%b rready=%b ird=%h lrd=%h exp 0/0/0/0/0", i, ifu_rvalid, lsu_rvalid, mem_rready, ifu_rdata, lsu_rdata); end
      cyc();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_ifu_only();
    test_lsu_priority();
    test_round_robin();
    test_rready_stall();
    test_reset_in_addr();
    test_arvalid_drop();
    test_stray_rvalid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_040750_rd_arbiter.md
Name: ysyx_040750_rd_arbiter

Overview:
Two-master, one-slave read-channel arbiter. It shares the single AR/R port of the memory/CLINT bus between the instruction fetch unit (IFU) and the load/store unit (LSU).
- One outstanding single-beat transaction at a time.
- The write channels (AW/W/B) are LSU-only and bypass this block.
- Sits between the IFU/LSU and the slave-side address decode (RAM, CLINT at 0x0200_0000).

Parameters:
LSU_PRIO, 1, 1 = LSU always wins ties; 0 = round-robin on ties
ADDR_W, 32, address width
DATA_W, 64, data width

Ports:
I_clk  in  1  clock
I_rst  in  1  reset, synchronous, active-high
I_ifu_araddr  in  ADDR_W  IFU read address
I_ifu_arvalid  in  1  IFU read request
O_ifu_arready  out  1  IFU address accepted
O_ifu_rdata  out  DATA_W  IFU read data
O_ifu_rvalid  out  1  IFU read data valid
I_ifu_rready  in  1  IFU ready for data
I_lsu_araddr  in  ADDR_W  LSU read address
I_lsu_arvalid  in  1  LSU read request
O_lsu_arready  out  1  LSU address accepted
O_lsu_rdata  out  DATA_W  LSU read data
O_lsu_rvalid  out  1  LSU read data valid
I_lsu_rready  in  1  LSU ready for data
O_mem_araddr  out  ADDR_W  slave read address
O_mem_arvalid  out  1  slave read request
I_mem_arready  in  1  slave address accepted
I_mem_rdata  in  DATA_W  slave read data
I_mem_rvalid  in  1  slave data valid
O_mem_rready  out  1  master ready for slave data
O_grant  out  2  current owner: 00 none, 01 IFU, 10 LSU

Behaviour:
Clock and reset: single clock I_clk; I_rst is synchronous, active-high.

FSM states: IDLE, ADDR, DATA. Owner register `own` ∈ {IFU, LSU}. Register `last` holds the most recent grant.

Reset values:
- state = IDLE, last = IFU.
- All outputs 0: O_grant = 00, all valid/ready = 0, rdata = 0, araddr = 0.

IDLE:
- All master arready/rvalid = 0; O_mem_arvalid = 0; O_mem_rready = 0.
- Only I_lsu_arvalid high: own = LSU, go to ADDR.
- Only I_ifu_arvalid high: own = IFU, go to ADDR.
- Both high:
  - LSU_PRIO = 1: grant LSU.
  - LSU_PRIO = 0: grant the master not equal to `last`.
- On grant: last <= owner.
- Neither high: stay in IDLE.

ADDR:
- Combinational pass-through of the owner's AR channel: O_mem_araddr/O_mem_arvalid = owner's araddr/arvalid; owner's arready = I_mem_arready.
- Non-owner arready = 0.
- O_mem_araddr = 0 whenever the state is not ADDR.
- Slave AR handshake: go to DATA.
- Owner arvalid low in ADDR (protocol violation): return to IDLE with nothing issued, no handshake.

DATA:
- Owner's rvalid/rdata = I_mem_rvalid/I_mem_rdata; O_mem_rready = owner's rready.
- Non-owner rvalid = 0, rdata = 0.
- R handshake (I_mem_rvalid && O_mem_rready): go to IDLE. Single beat only; no bursts.
- Owner stalls rready: stay in DATA indefinitely, no timeout.

Status and protocol rules:
- O_grant = 00 in IDLE; otherwise the owner code.
- The non-owner's arvalid stays pending, not dropped; it is granted in the next IDLE.
- I_mem_rvalid outside DATA is ignored: rready = 0 and nothing is forwarded.
- Minimum cost is 3 cycles per transaction with a zero-wait slave: IDLE(grant) → ADDR(AR handshake) → DATA(R handshake). Back-to-back requests always pass through IDLE.
- I_rst asserted in any state: the next state is IDLE and any in-flight transaction is dropped. The slave shares I_rst and is reset in the same cycle.
- No address decode and no data modification; widths pass through unchanged.
- Write ordering versus reads is the LSU's responsibility; the LSU issues no read while its write is outstanding.

Test Plan:
1. IFU-only read of 0x8000_0000, slave returns 0x1122_3344_5566_7788 on the cycle after the AR handshake → O_grant = 01; O_ifu_arready pulses in cycle 1; O_ifu_rvalid and that rdata in cycle 2; state is IDLE in cycle 3; LSU outputs stay 0.
2. IFU and LSU assert arvalid in the same cycle, LSU_PRIO = 1, LSU address 0x0200_BFF8 (mtime) → LSU served first (O_grant = 10, O_mem_araddr = 0x0200_BFF8); IFU granted in the following IDLE; IFU arready stays 0 until then.
3. LSU_PRIO = 0, both masters hold arvalid for 4 transactions → grant order LSU, IFU, LSU, IFU (last resets to IFU).
4. Owner in DATA holds rready = 0 for 5 cycles while I_mem_rvalid = 1 → state stays DATA, O_mem_rready = 0, rdata held; handshake on rready rise, then IDLE.
5. I_rst asserted while in ADDR with I_mem_arready = 0 → next cycle: IDLE, O_grant = 00, O_mem_arvalid = 0, all outputs 0.
6. Stray I_mem_rvalid = 1 in IDLE → no master rvalid asserted; O_mem_rready = 0.
